// File: rtl/mod_receptor_pf_pkg.sv
// -----------------------------------------------------------------------------
// pkg_alu_banderas
// Shared definitions for the ALU flag path (transmitter, receiver, flag logic).
//   estado_t  : receiver FSM states
//   ERR_CNT_W : width of the optional PF error counter
//   PF_MAX_W  : widest data word calc_pf accepts
//   calc_pf() : PF = 1 when the word holds an even number of ones (XNOR-reduce)
// Optional feature macro used by users of this package: CONTADOR_ERRORES_EN
// -----------------------------------------------------------------------------
package pkg_alu_banderas;

    typedef enum logic [1:0] {
        REPOSO  = 2'd0,
        DATOS   = 2'd1,
        PARIDAD = 2'd2,
        SALIDA  = 2'd3
    } estado_t;

    localparam int ERR_CNT_W = 8;
    localparam int PF_MAX_W  = 16;

    // Narrower words are passed zero-extended; extra zeros do not change parity.
    function automatic logic calc_pf(input logic [PF_MAX_W-1:0] dato);
        return ~(^dato);
    endfunction

endpackage

// File: rtl/mod_receptor_pf_if.sv
// -----------------------------------------------------------------------------
// mod_receptor_pf_if
// Bundle between the PF serial transmitter (master) and mod_receptor_pf (slave).
//   bit_valido, bit_in, cancelar : master -> slave
//   dato, pf_rx, error_pf, valido, ocupado (+ errores) : slave -> master
// Optional macro: CONTADOR_ERRORES_EN adds the 8-bit errores counter.
//
// Transfer rule: there is no ready signal. A bit moves on every rising edge
// where bit_valido = 1. The master must not start a new frame while
// ocupado = 1; strobes during the completion cycle are dropped. cancelar
// aborts the frame in progress and wins over a simultaneous bit_valido.
// -----------------------------------------------------------------------------
interface mod_receptor_pf_if #(
    parameter int ANCHO = 6
);
    import pkg_alu_banderas::*;

    logic             bit_valido;
    logic             bit_in;
    logic             cancelar;
    logic [ANCHO-1:0] dato;
    logic             pf_rx;
    logic             error_pf;
    logic             valido;
    logic             ocupado;
`ifdef CONTADOR_ERRORES_EN
    logic [ERR_CNT_W-1:0] errores;

    modport master (
        output bit_valido, bit_in, cancelar,
        input  dato, pf_rx, error_pf, valido, ocupado, errores
    );
    modport slave (
        input  bit_valido, bit_in, cancelar,
        output dato, pf_rx, error_pf, valido, ocupado, errores
    );
`else
    modport master (
        output bit_valido, bit_in, cancelar,
        input  dato, pf_rx, error_pf, valido, ocupado
    );
    modport slave (
        input  bit_valido, bit_in, cancelar,
        output dato, pf_rx, error_pf, valido, ocupado
    );
`endif

endinterface

// File: rtl/mod_receptor_pf_desplazador_rx.sv
// -----------------------------------------------------------------------------
// mod_desplazador_rx
// LSB-first shift register and bit counter for the PF receiver.
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_inicio     : load data bit 0 into a cleared register, counter := 1
//   i_desplazar  : shift in the next data bit, counter += 1
//   i_limpiar    : clear register and counter (highest priority)
//   i_bit        : serial data bit
//   palabra      : assembled word (bit 0 ends at index 0 after ANCHO bits)
//   ultimo_bit   : the next shift captures data bit ANCHO-1
// -----------------------------------------------------------------------------
module mod_desplazador_rx #(
    parameter int ANCHO = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_inicio,
    input  logic             i_desplazar,
    input  logic             i_limpiar,
    input  logic             i_bit,
    output logic [ANCHO-1:0] palabra,
    output logic             ultimo_bit
);
    localparam int CNT_W = $clog2(ANCHO + 1);

    logic [ANCHO-1:0] r_sr;
    logic [CNT_W-1:0] r_cnt;

    // Bits enter at the MSB and move right, so the first bit received
    // lands at index 0 once the whole word is in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr  <= '0;
            r_cnt <= '0;
        end else if (i_limpiar) begin
            r_sr  <= '0;
            r_cnt <= '0;
        end else if (i_inicio) begin
            r_sr  <= {i_bit, {(ANCHO-1){1'b0}}};
            r_cnt <= CNT_W'(1);
        end else if (i_desplazar) begin
            r_sr  <= {i_bit, r_sr[ANCHO-1:1]};
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // The counter equals the index of the bit the next strobe will carry.
    assign ultimo_bit = (r_cnt == CNT_W'(ANCHO - 1));
    assign palabra    = r_sr;

endmodule

// File: rtl/mod_receptor_pf.sv
// -----------------------------------------------------------------------------
// mod_receptor_pf
// Serial receiver for ALU result words with parity-flag (PF) check.
// Frame: ANCHO data bits LSB-first, then one PF bit, each marked by bit_valido.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : mod_receptor_pf_if.slave (strobe/data in, results out)
//   o_estado   : current FSM state, for observation only
// Optional macro: CONTADOR_ERRORES_EN adds bus.errores, a saturating count of
// completed frames whose received PF disagreed with the data.
// -----------------------------------------------------------------------------
import pkg_alu_banderas::*;

module mod_receptor_pf #(
    parameter int ANCHO = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mod_receptor_pf_if.slave      bus,
    output estado_t               o_estado
);
    estado_t          r_estado;
    estado_t          w_siguiente;
    logic             w_inicio;
    logic             w_desplazar;
    logic             w_limpiar;
    logic             w_cargar_pf;
    logic             w_cargar_salida;
    logic [ANCHO-1:0] w_palabra;
    logic             w_ultimo_bit;
    logic             w_pf_calc;

    logic             r_pf_bit;
    logic [ANCHO-1:0] r_dato;
    logic             r_pf_rx;
    logic             r_error_pf;
    logic             r_valido;
    logic             r_ocupado;

    mod_desplazador_rx #(.ANCHO(ANCHO)) u_desplazador (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_inicio    (w_inicio),
        .i_desplazar (w_desplazar),
        .i_limpiar   (w_limpiar),
        .i_bit       (bus.bit_in),
        .palabra     (w_palabra),
        .ultimo_bit  (w_ultimo_bit)
    );

    assign w_pf_calc = calc_pf(PF_MAX_W'(w_palabra));

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_estado <= REPOSO;
        else        r_estado <= w_siguiente;
    end

    // FSM: next state; cancelar overrides everything
    always_comb begin
        w_siguiente = r_estado;
        if (bus.cancelar) begin
            w_siguiente = REPOSO;
        end else begin
            case (r_estado)
                REPOSO:  if (bus.bit_valido) w_siguiente = DATOS;
                DATOS:   if (bus.bit_valido && w_ultimo_bit) w_siguiente = PARIDAD;
                PARIDAD: if (bus.bit_valido) w_siguiente = SALIDA;
                SALIDA:  w_siguiente = REPOSO;
                default: w_siguiente = REPOSO;
            endcase
        end
    end

    // FSM: control outputs
    always_comb begin
        w_limpiar       = bus.cancelar;
        w_inicio        = 1'b0;
        w_desplazar     = 1'b0;
        w_cargar_pf     = 1'b0;
        w_cargar_salida = 1'b0;
        if (!bus.cancelar) begin
            w_inicio        = (r_estado == REPOSO)  && bus.bit_valido;
            w_desplazar     = (r_estado == DATOS)   && bus.bit_valido;
            w_cargar_pf     = (r_estado == PARIDAD) && bus.bit_valido;
            w_cargar_salida = (r_estado == SALIDA);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pf_bit   <= 1'b0;
            r_dato     <= '0;
            r_pf_rx    <= 1'b0;
            r_error_pf <= 1'b0;
            r_valido   <= 1'b0;
            r_ocupado  <= 1'b0;
        end else begin
            if (w_cargar_pf) r_pf_bit <= bus.bit_in;
            if (w_cargar_salida) begin
                r_dato     <= w_palabra;
                r_pf_rx    <= r_pf_bit;
                r_error_pf <= (r_pf_bit != w_pf_calc);
            end
            r_valido  <= w_cargar_salida;
            // Registered from the next state so it tracks state != REPOSO exactly.
            r_ocupado <= (w_siguiente != REPOSO);
        end
    end

`ifdef CONTADOR_ERRORES_EN
    logic [ERR_CNT_W-1:0] r_errores;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_errores <= '0;
        end else if (w_cargar_salida && (r_pf_bit != w_pf_calc) && (r_errores != '1)) begin
            r_errores <= r_errores + ERR_CNT_W'(1);
        end
    end

    assign bus.errores = r_errores;
`endif

    assign bus.dato     = r_dato;
    assign bus.pf_rx    = r_pf_rx;
    assign bus.error_pf = r_error_pf;
    assign bus.valido   = r_valido;
    assign bus.ocupado  = r_ocupado;
    assign o_estado     = r_estado;

endmodule
